// File: rtl/freq_generator_pkg.sv
// Shared constants and types for the square-wave generator and its BCD front end.
// Window defaults are common with the frequency counter.
package freq_generator_pkg;

  localparam int DEF_UPDATE_PERIOD = 1200;
  localparam int DEF_BITS          = 12;
  localparam int DEF_MIN_PERIOD    = 200;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    COMMIT  = 3'd2
  } conv_state_e;

  function automatic logic bcd_digits_ok(input logic [3:0] t, input logic [3:0] u);
    return (t <= BCD_DIGIT_MAX) && (u <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/freq_generator_bcd_to_bin.sv
// Iterative two-digit BCD to binary converter: adds 10 once per tens count,
// then presents bin + units for one COMMIT cycle (done_o high).
module freq_generator_bcd_to_bin
  import freq_generator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  tens_i,
  input  logic [3:0]  units_i,
  output conv_state_e state_o,
  output logic        done_o,
  output logic [6:0]  bin_o
);

  conv_state_e state_q, state_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic [6:0]  bin_q, bin_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      bin_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    bin_d   = bin_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tens_d  = tens_i;
          units_d = units_i;
          bin_d   = 7'd0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (tens_q != 4'd0) begin
          bin_d  = bin_q + 7'd10;
          tens_d = tens_q - 4'd1;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign bin_o   = bin_q + {3'b000, units_q};

endmodule

// File: rtl/freq_generator.sv
// Programmable square-wave source: N evenly spaced rising edges per window of
// active_p clk cycles, using a Bresenham-style accumulator stepping by 2N.
module freq_generator
  import freq_generator_pkg::*;
#(
  parameter int UPDATE_PERIOD = DEF_UPDATE_PERIOD,
  parameter int BITS          = DEF_BITS,
  parameter int MIN_PERIOD    = DEF_MIN_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      tens,
  input  logic [3:0]      units,
  input  logic            value_load,
  output logic            ready,
  output logic            load_err,
  input  logic [BITS-1:0] period,
  input  logic            period_load,
  output logic            signal,
  output logic            period_start
);

  // value_load is a single-cycle request taken only when ready is high and both
  // digits are valid BCD; any other request is dropped and answered with load_err.
  conv_state_e     conv_state;
  logic            conv_done;
  logic [6:0]      conv_bin;
  logic            conv_start;

  logic            load_err_q, load_err_d;
  logic [6:0]      pending_n_q, pending_n_d;
  logic [6:0]      active_n_q, active_n_d;
  logic [BITS-1:0] pending_p_q, pending_p_d;
  logic [BITS-1:0] active_p_q, active_p_d;
  logic [BITS-1:0] cycle_count_q, cycle_count_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic            signal_q, signal_d;
  logic            period_start_q, period_start_d;
  logic [BITS:0]   sum;

  assign ready      = (conv_state == IDLE);
  assign conv_start = value_load && ready && bcd_digits_ok(tens, units);

  freq_generator_bcd_to_bin u_bcd_to_bin (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .tens_i  (tens),
    .units_i (units),
    .state_o (conv_state),
    .done_o  (conv_done),
    .bin_o   (conv_bin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_q     <= 1'b0;
      pending_n_q    <= 7'd0;
      active_n_q     <= 7'd0;
      pending_p_q    <= BITS'(UPDATE_PERIOD);
      active_p_q     <= BITS'(UPDATE_PERIOD);
      cycle_count_q  <= '0;
      acc_q          <= '0;
      signal_q       <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      load_err_q     <= load_err_d;
      pending_n_q    <= pending_n_d;
      active_n_q     <= active_n_d;
      pending_p_q    <= pending_p_d;
      active_p_q     <= active_p_d;
      cycle_count_q  <= cycle_count_d;
      acc_q          <= acc_d;
      signal_q       <= signal_d;
      period_start_q <= period_start_d;
    end
  end

  always_comb begin
    load_err_d  = value_load && !conv_start;
    pending_n_d = conv_done ? conv_bin : pending_n_q;
    pending_p_d = pending_p_q;
    if (period_load) begin
      pending_p_d = (period < BITS'(MIN_PERIOD)) ? BITS'(MIN_PERIOD) : period;
    end
  end

  // With 2N <= active_p the accumulator wraps at most once per cycle, so one
  // toggle per cycle suffices; the last falling edge comes from the boundary clear.
  always_comb begin
    sum            = {1'b0, acc_q} + {{(BITS-7){1'b0}}, active_n_q, 1'b0};
    cycle_count_d  = cycle_count_q;
    acc_d          = acc_q;
    signal_d       = signal_q;
    period_start_d = 1'b0;
    active_n_d     = active_n_q;
    active_p_d     = active_p_q;
    if (cycle_count_q == active_p_q - BITS'(1)) begin
      cycle_count_d  = '0;
      acc_d          = '0;
      signal_d       = 1'b0;
      period_start_d = 1'b1;
      active_n_d     = pending_n_q;
      active_p_d     = pending_p_q;
    end else begin
      cycle_count_d = cycle_count_q + BITS'(1);
      if (sum >= {1'b0, active_p_q}) begin
        acc_d    = sum[BITS-1:0] - active_p_q;
        signal_d = ~signal_q;
      end else begin
        acc_d = sum[BITS-1:0];
      end
    end
  end

  assign load_err     = load_err_q;
  assign signal       = signal_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_freq_generator.sv
// Bench for freq_generator: window-level model predicts signal from
// floor(2*N*c/P) parity, plus directed literal checks on latency and window length.
module tb_freq_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  tens = 4'd0;
  logic [3:0]  units = 4'd0;
  logic        value_load = 1'b0;
  logic [11:0] period = 12'd0;
  logic        period_load = 1'b0;
  logic        ready, load_err, signal, period_start;

  int vectors = 0;
  int miscompares = 0;

  freq_generator dut (
    .clk          (clk),
    .reset        (reset),
    .tens         (tens),
    .units        (units),
    .value_load   (value_load),
    .ready        (ready),
    .load_err     (load_err),
    .period       (period),
    .period_load  (period_load),
    .signal       (signal),
    .period_start (period_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: act=%0d req=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // window-level model
  int m_c, m_an, m_pn, m_ap, m_pp, m_busy, m_tgt, m_last_an;
  bit m_ps, m_err, m_full, m_win_ok, m_valid, m_in_reset;

  always @(posedge clk) begin
    if (reset) begin
      m_c = 0; m_an = 0; m_pn = 0; m_ap = 1200; m_pp = 1200;
      m_busy = 0; m_ps = 0; m_err = 0; m_full = 0; m_win_ok = 0;
      m_valid = 1; m_in_reset = 1;
    end else if (m_valid) begin
      m_in_reset = 0;
      m_err = value_load && (m_busy != 0 || tens > 9 || units > 9);
      if (m_c == m_ap - 1) begin
        m_last_an = m_an;
        m_win_ok  = m_full;
        m_full    = 1;
        m_c = 0; m_an = m_pn; m_ap = m_pp; m_ps = 1;
      end else begin
        m_c++; m_ps = 0;
      end
      if (m_busy != 0) begin
        m_busy--;
        if (m_busy == 0) m_pn = m_tgt;
      end else if (value_load && tens <= 9 && units <= 9) begin
        m_busy = int'(tens) + 2;
        m_tgt  = int'(tens) * 10 + int'(units);
      end
      if (period_load) m_pp = (period < 200) ? 200 : int'(period);
    end
  end

  function automatic int exp_signal();
    if (m_c == 0) return 0;
    return ((2 * m_an * m_c) / m_ap) % 2;
  endfunction

  // scoreboard: every cycle once the model has seen reset
  int  rises = 0;
  logic prev_sig = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      check("signal", int'(signal), exp_signal());
      check("period_start", int'(period_start), int'(m_ps));
      check("ready", int'(ready), (m_busy == 0) ? 1 : 0);
      check("load_err", int'(load_err), int'(m_err));
      if (m_in_reset) begin
        rises = 0;
      end else if (m_ps) begin
        if (m_win_ok) check("rises_per_window", rises, m_last_an);
        rises = 0;
      end else if (signal && !prev_sig) begin
        rises++;
      end
      prev_sig = signal;
    end
  end

  // drivers
  task automatic pulse_load(input logic [3:0] t, input logic [3:0] u);
    tens = t; units = u; value_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0;
  endtask

  task automatic load_and_time(input logic [3:0] t, input logic [3:0] u, input int exp_low);
    int n = 0;
    pulse_load(t, u);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_low_cycles", n, exp_low);
  endtask

  task automatic wait_ps(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < budget);
    if (!period_start) check("period_start_timeout", 0, 1);
  endtask

  task automatic wait_c(input int target);
    int n = 0;
    while (m_c != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_cycle", m_c, target);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_signal", int'(signal), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_load_err", int'(load_err), 0);
    reset = 1'b0;

    // N=1: single rising edge at the half-window point
    load_and_time(4'd0, 4'd1, 2);
    wait_ps(1300);
    wait_c(599);
    check("n1_sig_c599", int'(signal), 0);
    @(negedge clk);
    check("n1_sig_c600", int'(signal), 1);
    wait_c(1199);
    check("n1_sig_c1199", int'(signal), 1);
    wait_ps(10);
    check("n1_sig_c0", int'(signal), 0);

    // N=99
    load_and_time(4'd9, 4'd9, 11);
    wait_ps(1300);
    wait_ps(1300);
    wait_ps(1300);

    // rejected loads
    pulse_load(4'hA, 4'd0);
    check("bad_digit_err", int'(load_err), 1);
    check("bad_digit_ready", int'(ready), 1);
    @(negedge clk);
    check("bad_digit_err_clear", int'(load_err), 0);
    pulse_load(4'd1, 4'd2);
    pulse_load(4'd3, 4'd4);
    check("busy_load_err", int'(load_err), 1);
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end

    // period clamp, applied only at the next boundary
    wait_ps(1300);
    n = 0;
    repeat (300) begin @(negedge clk); n++; end
    period = 12'd50; period_load = 1'b1;
    @(negedge clk); n++;
    period_load = 1'b0;
    while (!period_start && n < 2000) begin @(negedge clk); n++; end
    check("win_len_before_clamp", n, 1200);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 2000);
    check("win_len_clamped", n, 200);
    wait_ps(300);

    // mid-window reset with signal high
    load_and_time(4'd0, 4'd1, 2);
    period = 12'd1200; period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
    wait_ps(300);
    wait_c(700);
    check("pre_reset_sig", int'(signal), 1);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_sig", int'(signal), 0);
    check("post_reset_ps", int'(period_start), 0);
    reset = 1'b0;
    n = 0;
    prev_sig = signal;
    for (int i = 0; i < 1300; i++) begin
      logic s0;
      s0 = signal;
      @(negedge clk);
      if (signal && !s0) n++;
    end
    check("post_reset_rises", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_generator.md
Name: freq_generator

Overview:
- Programmable square-wave source, the transmit-side counterpart of the frequency counter. It takes a two-digit BCD target N (0-99).
- It emits exactly N evenly spaced rising edges on `signal` in every update window of `update_period` clk cycles.
- Used as an on-chip stimulus source and as loopback into the frequency counter's `signal` input.

Parameters:
- UPDATE_PERIOD, 1200, reset value of the window length in clk cycles.
- BITS, 12, width of the period/cycle counter.
- MIN_PERIOD, 200, smallest legal window (2*99+2). Smaller loads are clamped to this value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tens  in  4  BCD tens digit of N
- units  in  4  BCD units digit of N
- value_load  in  1  one-cycle request to capture tens/units
- ready  out  1  high when value_load will be accepted
- load_err  out  1  one-cycle pulse: load rejected (digit > 9, or ready low)
- period  in  BITS  new window length
- period_load  in  1  capture period
- signal  out  1  generated waveform
- period_start  out  1  one-cycle pulse, high in the first cycle of each window

Behaviour:
- Reset values:
  - signal=0, period_start=0, ready=1, load_err=0.
  - active_n=pending_n=0, active_p=pending_p=UPDATE_PERIOD.
  - cycle_count=0, acc=0, state=IDLE.
- Control FSM (3-bit state register):
  - IDLE: ready=1. On value_load with tens<=9 and units<=9: latch the digits, bin=0, go to CONVERT, ready=0 next cycle.
    - Digit >9: stay in IDLE, load_err=1 for one cycle, no other change.
  - CONVERT: while tens_r != 0, bin += 10 and tens_r -= 1, one step per cycle. When tens_r == 0, go to COMMIT.
  - COMMIT: pending_n = bin + units_r (7 bits), return to IDLE. Total latency from load to pending_n is tens+2 cycles.
  - value_load while ready=0: load_err pulse, request ignored.
  - Unused state encodings: go to IDLE.
- period_load: pending_p = max(period, MIN_PERIOD). Accepted in any state. Last write before the boundary wins.
- Generator runs every cycle, independent of the FSM:
  - Boundary (cycle_count == active_p-1):
    - cycle_count<=0, acc<=0, signal<=0, period_start<=1.
    - active_n<=pending_n, active_p<=pending_p.
  - Otherwise:
    - cycle_count++, period_start<=0.
    - s = acc + 2*active_n (width BITS+1).
    - If s >= active_p: acc<=s-active_p and signal toggles. Else acc<=s.
  - Because 2N <= active_p, there is at most one toggle per cycle.
  - The final falling edge of each window is produced by the boundary clear.
  - Result: exactly N rising edges per window, with duty ~50%.
- N=0: signal held 0, period_start still pulses.
- New N or period values never take effect mid-window, only at the next boundary.
- Reset asserted mid-window or mid-CONVERT: everything returns to reset values next cycle. The window restarts at cycle_count=0 with no period_start pulse until the first boundary.

Decomposition:
- Shared package holds:
  - default UPDATE_PERIOD and BITS (common with the frequency counter);
  - MIN_PERIOD;
  - FSM state constants IDLE/CONVERT/COMMIT;
  - BCD digit-max constant 9.
- One natural sub-module, bcd_to_bin: the iterative CONVERT/COMMIT datapath with a start/done handshake. The window/accumulator logic stays in the top.

Test Plan:
- reset, load tens=0 units=1, P=1200 ->
  - ready drops for 2 cycles;
  - in window 2, signal rises at cycle_count=600 and stays high through 1199;
  - signal is low at cycle_count 0;
  - exactly 1 rising edge per window.
- load tens=9 units=9 ->
  - ready low for 11 cycles;
  - from the next boundary, 99 rising edges per 1200-cycle window;
  - no two toggles in one cycle.
- load tens=10 (0xA) -> load_err pulse, ready stays 1, active_n unchanged. A second value_load during CONVERT -> load_err pulse.
- period_load period=50 mid-window -> current window stays 1200 cycles; next window is 200 cycles (clamp), with N edges.
- loopback into frequency counter with N=42, both at P=1200 -> displayed count 42±1 every update.
- reset asserted at cycle_count=700 with signal high -> next cycle signal=0, cycle_count=0, pending_n=0. Afterwards, no edges.
